// File: rtl/channel_monitor_recorder_if.sv
// Monitor-in / record-out channel bundle for channel_monitor_recorder.
// The DUT takes the slave side; the producer/consumer environment takes the master side.
interface channel_monitor_recorder_if #(
    parameter int TS_WIDTH = 16
);
    logic                  monitor_ready;
    logic                  monitor_valid;
    logic [9:0]            monitor_data;
    logic                  record_ready;
    logic                  record_valid;
    logic [TS_WIDTH+7:0]   record_data;
    logic                  overflow;
    logic [7:0]            drop_count;

    modport master (
        output monitor_valid,
        output monitor_data,
        output record_ready,
        input  monitor_ready,
        input  record_valid,
        input  record_data,
        input  overflow,
        input  drop_count
    );

    modport slave (
        input  monitor_valid,
        input  monitor_data,
        input  record_ready,
        output monitor_ready,
        output record_valid,
        output record_data,
        output overflow,
        output drop_count
    );
endinterface

// File: rtl/channel_monitor_recorder.sv
// Timestamps observed channel beats and buffers {ts, data} records in a FIFO,
// counting captures lost when the FIFO is full and nothing drains that cycle.
module channel_monitor_recorder #(
    parameter int DEPTH    = 8,
    parameter int TS_WIDTH = 16
) (
    input logic                       clk,
    input logic                       rst,
    channel_monitor_recorder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = TS_WIDTH + 8;

    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic [AW-1:0]       wrPtr_q, wrPtr_d;
    logic [AW-1:0]       rdPtr_q, rdPtr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                overflow_q, overflow_d;
    logic [7:0]          dropCount_q, dropCount_d;
    logic [RW-1:0]       mem_q [DEPTH];

    logic capture;
    logic fifoEmpty;
    logic fifoFull;
    logic pop;
    logic push;
    logic drop;
    logic unusedMonitorBit;

    assign unusedMonitorBit = bus.monitor_data[8];

    assign fifoEmpty = (count_q == '0);
    assign fifoFull  = (count_q == CW'(DEPTH));
    assign capture   = !rst && bus.monitor_valid && bus.monitor_data[9];
    assign pop       = !rst && !fifoEmpty && bus.record_ready;
    // A full FIFO still accepts a capture when the head leaves in the same cycle.
    assign push      = capture && (!fifoFull || pop);
    assign drop      = capture && fifoFull && !pop;

    always_comb begin
        ts_d        = ts_q + TS_WIDTH'(1);
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        dropCount_d = dropCount_q;
        if (push) begin
            wrPtr_d = wrPtr_q + AW'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (dropCount_q != 8'hFF) begin
                dropCount_d = dropCount_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q        <= '0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            dropCount_q <= 8'd0;
        end else begin
            ts_q        <= ts_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            dropCount_q <= dropCount_d;
        end
    end

    // Storage needs no reset: pointers and occupancy alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wrPtr_q] <= {ts_q, bus.monitor_data[7:0]};
        end
    end

    assign bus.monitor_ready = 1'b1;
    assign bus.record_valid  = !fifoEmpty;
    assign bus.record_data   = mem_q[rdPtr_q];
    assign bus.overflow      = overflow_q;
    assign bus.drop_count    = dropCount_q;
endmodule

// File: doc/channel_monitor_recorder.md
CHANNEL_MONITOR_RECORDER -- requirements
Module: channel_monitor_recorder

Interface
REQ-001 Parameter DEPTH, default 8, is the record FIFO depth; it SHALL be a power of two and at least 2.
REQ-002 Parameter TS_WIDTH, default 16, is the timestamp counter width.
REQ-003 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  is the reset; reset is synchronous and active-high.
REQ-005 Port monitor_ready  output  1  is the monitor-channel ready; it SHALL be tied 1 (a sample is consumed every cycle).
REQ-006 Port monitor_valid  input  1  is the monitor-channel valid.
REQ-007 Port monitor_data  input  10  is the monitor sample: bit 9 = observed channel valid, bits 7:0 = observed channel data, bit 8 = ignored.
REQ-008 Port record_ready  input  1  is the downstream ready.
REQ-009 Port record_valid  output  1  is the record-channel valid.
REQ-010 Port record_data  output  TS_WIDTH+8  is the record {timestamp, data[7:0]}, with the timestamp in the MSBs.
REQ-011 Port overflow  output  1  is a sticky flag meaning at least one capture was dropped.
REQ-012 Port drop_count  output  8  is the number of dropped captures, saturating.

Function
REQ-013 Timestamp counter ts SHALL increment by 1 every cycle out of reset and wrap from 2^TS_WIDTH-1 to 0.
REQ-014 Capture condition: monitor_valid=1 AND monitor_data[9]=1 in cycle N.
REQ-015 A capture in cycle N SHALL form the record {ts value in cycle N, monitor_data[7:0]}.
REQ-016 A capture pushes the record into a DEPTH-entry FIFO; the record SHALL be visible on record_valid/record_data in cycle N+1 at the earliest.
REQ-017 record_valid SHALL equal FIFO non-empty; record_data SHALL present the oldest entry.
REQ-018 A pop occurs when record_valid=1 AND record_ready=1.
REQ-019 While record_valid=1 and record_ready=0, record_data SHALL be held stable.
REQ-020 Records SHALL be delivered in capture order, with no duplication and no loss except as defined by REQ-022.
REQ-021 FIFO full with a pop and a capture in the same cycle: the capture SHALL be accepted, and occupancy SHALL stay at DEPTH.
REQ-022 FIFO full with a capture and no pop: the capture SHALL be dropped, overflow SHALL be set to 1, and drop_count SHALL increment, saturating at 255.
REQ-023 Empty FIFO with a capture and record_ready=1: no pop SHALL occur that cycle, and occupancy SHALL become 1.
REQ-024 The occupancy counter SHALL have log2(DEPTH)+1 bits; read and write pointers SHALL wrap modulo DEPTH.
REQ-025 monitor_data bit 8 and cycles without a capture SHALL have no effect on the FIFO.

Reset
REQ-026 When rst=1 at a rising edge, the following SHALL hold from the next cycle: ts=0, FIFO empty (record_valid=0), overflow=0, drop_count=0.
REQ-027 Reset asserted mid-operation SHALL discard all buffered records; no record SHALL be emitted after reset unless it was captured after reset.
REQ-028 A capture in a cycle where rst=1 SHALL be ignored.
REQ-029 monitor_ready SHALL be 1 during reset.
REQ-030 record_data SHALL be don't-care while record_valid=0.

Verification
REQ-031 Single capture: release reset; in cycle 5 after release, drive monitor_valid=1, monitor_data=10'h2A5 -> next cycle record_valid=1 and record_data={16'd5, 8'hA5}.
REQ-032 Backpressure/full: record_ready=0 and 9 consecutive captures of data 0..8, DEPTH=8 -> 8 records held; overflow=1 and drop_count=1; then record_ready=1 -> data 0..7 emitted in order, followed by record_valid=0.
REQ-033 Full with simultaneous pop: FIFO full, record_ready=1, capture data 8'h77 -> accepted, overflow stays 0, and 8'h77 is emitted last.
REQ-034 Filtering and wrap: drive monitor_data[9]=0 with monitor_valid=1 -> no record; run 65536 cycles, then capture -> timestamp has wrapped to the expected modulo value.
REQ-035 Saturation and mid-operation reset: 300 drops -> drop_count=255; assert rst for 1 cycle with 4 records buffered -> record_valid=0, overflow=0, drop_count=0, ts=0 on the following cycle.
